// File: rtl/instr_fetch_server.sv
// Program-memory responder for the CPU instruction-fetch port.
// Accepts one fetch at a time, waits LATENCY cycles, returns the word over a
// valid/ready response channel. The load port writes the array independently.
module instr_fetch_server #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [15:0]       fetch_count
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   instr_d;
  logic                err_d;
  logic [CNT_W-1:0]    count_d;
  logic                accept;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_ok;
  logic [DATA_W-1:0]   cap_data;
  logic                load_ok;

  // Capture address: latched request while waiting, live request on a zero-latency accept
  assign cap_addr = (state_q == S_WAIT) ? addr_q : fetch_addr;
  assign cap_ok   = 32'(cap_addr) < DEPTH;
  assign cap_data = cap_ok ? mem[IDX_W'(cap_addr)] : '0;
  assign load_ok  = 32'(load_addr) < DEPTH;

  // Program array write; not cleared by reset, out-of-range loads dropped
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[IDX_W'(load_addr)] <= load_data;
    end
  end

  // Next-state, handshake and counter logic
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    instr_d     = rsp_instr;
    err_d       = rsp_err;
    count_d     = fetch_count;
    fetch_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    accept      = fetch_valid && fetch_ready;

    case (state_q)
      S_WAIT: begin
        if (wait_q == WAIT_W'(LATENCY)) begin
          state_d = S_RESP;
          instr_d = cap_data;
          err_d   = !cap_ok;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
      end
    endcase

    // A new request (from IDLE or drain-and-accept in RESP) overrides the above
    if (accept) begin
      addr_d = fetch_addr;
      wait_d = '0;
      if (LATENCY == 0) begin
        state_d = S_RESP;
        instr_d = cap_data;
        err_d   = !cap_ok;
      end else begin
        state_d = S_WAIT;
      end
    end

    if (rsp_valid && rsp_ready && (fetch_count != '1)) begin
      count_d = fetch_count + CNT_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_instr   <= '0;
      rsp_err     <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      rsp_valid   <= (state_d == S_RESP);
      rsp_instr   <= instr_d;
      rsp_err     <= err_d;
      fetch_count <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_server.sv
// Directed bench for instr_fetch_server: instance a (LATENCY=2, DEPTH=256),
// instance b (LATENCY=0, DEPTH=128).
module tb_instr_fetch_server;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic       a_rst, a_fv, a_fr, a_rv, a_rr, a_re, a_le;
  logic [7:0] a_fa, a_ri, a_la, a_ld;
  logic [15:0] a_fc;
  // Instance b signals
  logic       b_rst, b_fv, b_fr, b_rv, b_rr, b_re, b_le;
  logic [7:0] b_fa, b_ri, b_la, b_ld;
  logic [15:0] b_fc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  instr_fetch_server #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(2)) u_a (
    .clk(clk), .reset(a_rst),
    .fetch_valid(a_fv), .fetch_addr(a_fa), .fetch_ready(a_fr),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_instr(a_ri), .rsp_err(a_re),
    .load_en(a_le), .load_addr(a_la), .load_data(a_ld), .fetch_count(a_fc)
  );

  instr_fetch_server #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .LATENCY(0)) u_b (
    .clk(clk), .reset(b_rst),
    .fetch_valid(b_fv), .fetch_addr(b_fa), .fetch_ready(b_fr),
    .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_instr(b_ri), .rsp_err(b_re),
    .load_en(b_le), .load_addr(b_la), .load_data(b_ld), .fetch_count(b_fc)
  );

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_fv = 1'b0; a_fa = '0; a_rr = 1'b0; a_le = 1'b0; a_la = '0; a_ld = '0;
    b_rst = 1'b1; b_fv = 1'b0; b_fa = '0; b_rr = 1'b0; b_le = 1'b0; b_la = '0; b_ld = '0;
    step();
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    chk("a_reset_rv", 32'(a_rv), 32'd0);
    chk("a_reset_ri", 32'(a_ri), 32'd0);
    chk("a_reset_re", 32'(a_re), 32'd0);
    chk("a_reset_fc", 32'(a_fc), 32'd0);
    chk("a_reset_fr", 32'(a_fr), 32'd1);
    chk("b_reset_fc", 32'(b_fc), 32'd0);

    // Load 0x10 <= A5, then fetch it with LATENCY=2
    a_le = 1'b1; a_la = 8'h10; a_ld = 8'hA5;
    step();
    a_le = 1'b0;
    a_fv = 1'b1; a_fa = 8'h10;
    step();                      // accept edge k
    a_fv = 1'b0; a_fa = 8'h55;   // later address changes must not matter
    chk("a_wait_fr", 32'(a_fr), 32'd0);
    chk("a_wait_rv0", 32'(a_rv), 32'd0);
    step();                      // k+1
    chk("a_wait_rv1", 32'(a_rv), 32'd0);
    step();                      // k+2
    chk("a_wait_rv2", 32'(a_rv), 32'd0);
    step();                      // k+3: response visible
    chk("a_t1_rv", 32'(a_rv), 32'd1);
    chk("a_t1_ri", 32'(a_ri), 32'hA5);
    chk("a_t1_re", 32'(a_re), 32'd0);

    // Backpressure for 5 cycles; a load during it must not disturb anything
    for (int i = 0; i < 5; i++) begin
      a_le = (i == 0); a_la = 8'h20; a_ld = 8'h11;
      step();
      chk("a_bp_rv", 32'(a_rv), 32'd1);
      chk("a_bp_ri", 32'(a_ri), 32'hA5);
      chk("a_bp_fr", 32'(a_fr), 32'd0);
    end
    a_le = 1'b0;
    chk("a_bp_fc", 32'(a_fc), 32'd0);

    // Drain and accept a new request on the same edge
    a_rr = 1'b1; a_fv = 1'b1; a_fa = 8'h20;
    #1;
    chk("a_drain_fr", 32'(a_fr), 32'd1);
    step();                      // edge m
    a_rr = 1'b0; a_fv = 1'b0;
    chk("a_t1_fc", 32'(a_fc), 32'd1);
    chk("a_drain_rv", 32'(a_rv), 32'd0);
    step();                      // m+1
    step();                      // m+2
    // Load 0x20 <= 3C on the capture edge: old 11 must be returned
    a_le = 1'b1; a_la = 8'h20; a_ld = 8'h3C;
    step();                      // m+3 capture
    a_le = 1'b0;
    chk("a_rbw_rv", 32'(a_rv), 32'd1);
    chk("a_rbw_old", 32'(a_ri), 32'h11);
    a_rr = 1'b1; a_fv = 1'b1; a_fa = 8'h20;
    step();
    a_rr = 1'b0; a_fv = 1'b0;
    chk("a_t3_fc", 32'(a_fc), 32'd2);
    step(); step(); step();
    chk("a_rbw_new", 32'(a_ri), 32'h3C);
    a_rr = 1'b1;
    step();
    a_rr = 1'b0;
    chk("a_idle_fc", 32'(a_fc), 32'd3);
    chk("a_idle_rv", 32'(a_rv), 32'd0);
    step();
    chk("a_idle_hold", 32'(a_ri), 32'h3C);

    // Reset during WAIT aborts the fetch
    a_fv = 1'b1; a_fa = 8'h10;
    step();
    a_fv = 1'b0;
    step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    chk("a_abort_rv", 32'(a_rv), 32'd0);
    chk("a_abort_fr", 32'(a_fr), 32'd1);
    step(); step(); step();
    chk("a_abort_stay", 32'(a_rv), 32'd0);
    // Memory survives reset
    a_fv = 1'b1; a_fa = 8'h10;
    step();
    a_fv = 1'b0;
    step(); step(); step();
    chk("a_mem_kept_rv", 32'(a_rv), 32'd1);
    chk("a_mem_kept_ri", 32'(a_ri), 32'hA5);
    a_rr = 1'b1;
    step();
    a_rr = 1'b0;
    chk("a_post_rst_fc", 32'(a_fc), 32'd1);

    // Instance b: load 0..9 with 40+i, attempt out-of-range load to 0x90
    for (int i = 0; i < 10; i++) begin
      b_le = 1'b1; b_la = 8'(i); b_ld = 8'(8'h40 + i);
      step();
    end
    b_la = 8'h90; b_ld = 8'hEE;
    step();
    b_le = 1'b0;

    // Out-of-range fetch, zero latency
    b_fv = 1'b1; b_fa = 8'h90;
    step();
    b_fv = 1'b0;
    chk("b_oor_rv", 32'(b_rv), 32'd1);
    chk("b_oor_ri", 32'(b_ri), 32'd0);
    chk("b_oor_err", 32'(b_re), 32'd1);
    b_rr = 1'b1;
    step();
    b_rr = 1'b0;
    chk("b_oor_fc", 32'(b_fc), 32'd1);
    chk("b_oor_rv_drop", 32'(b_rv), 32'd0);

    // Clear the count, then stream addresses 0..9
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    chk("b_rst_fc", 32'(b_fc), 32'd0);
    b_fv = 1'b1; b_rr = 1'b1; b_fa = 8'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("b_stream_rv", 32'(b_rv), 32'd1);
      chk("b_stream_ri", 32'(b_ri), 32'(8'h40 + i));
      chk("b_stream_re", 32'(b_re), 32'd0);
      if (i < 9) b_fa = 8'(i + 1);
      else       b_fv = 1'b0;
    end
    step();
    chk("b_stream_fc", 32'(b_fc), 32'd10);
    chk("b_stream_end_rv", 32'(b_rv), 32'd0);

    // Saturation: after N streaming edges the count is 10 + N - 1
    b_fv = 1'b1; b_fa = 8'd3;
    repeat (65525) step();
    chk("b_cnt_fffe", 32'(b_fc), 32'hFFFE);
    step();
    chk("b_cnt_ffff", 32'(b_fc), 32'hFFFF);
    repeat (3) step();
    chk("b_cnt_sat", 32'(b_fc), 32'hFFFF);
    chk("b_sat_ri", 32'(b_ri), 32'h43);
    b_fv = 1'b0; b_rr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
